// File: rtl/axis_tg_pkg.sv
// Shared AXI-Stream constants and arbiter state encoding for the traffic-generator datapath.
package axis_tg_pkg;

    localparam int unsigned AXIS_DW = 512;
    localparam int unsigned AXIS_KW = 64;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axis_rr_pkt_arbiter_if.sv
// Bundled per-port sink streams and the merged 512-bit source stream of the packet arbiter.
interface axis_rr_pkt_arbiter_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = 2
);
    import axis_tg_pkg::*;

    logic [NUM_PORTS-1:0]         s_valid;
    logic [NUM_PORTS-1:0]         s_ready;
    logic [NUM_PORTS*AXIS_DW-1:0] s_data;
    logic [NUM_PORTS*AXIS_KW-1:0] s_keep;
    logic [NUM_PORTS-1:0]         s_last;

    logic                         m_valid;
    logic                         m_ready;
    logic [AXIS_DW-1:0]           m_data;
    logic [AXIS_KW-1:0]           m_keep;
    logic                         m_last;
    logic [PORT_W-1:0]            m_src;

    // Traffic side: drives the generator lanes and the downstream ready.
    modport master (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last, m_src
    );

    // Arbiter side.
    modport slave (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last, m_src
    );

endinterface

// File: rtl/axis_rr_pkt_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning upward from last_grant+1, modulo NUM_PORTS.
module rr_pick #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_grant,
    output logic                 any,
    output logic [PORT_W-1:0]    winner
);

    logic [PORT_W-1:0] idx;

    assign any = |req;

    // Scan farthest-first so the nearest requester after last_grant overwrites the others.
    always_comb begin
        idx    = '0;
        winner = '0;
        for (int k = int'(NUM_PORTS); k >= 1; k--) begin
            idx = PORT_W'((32'(last_grant) + 32'(k)) % NUM_PORTS);
            if (req[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream lanes onto one registered 512-bit output.
module axis_rr_pkt_arbiter
    import axis_tg_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_rr_pkt_arbiter_if.slave bus,
    input  logic [NUM_PORTS-1:0] en_mask,
    output logic                 busy,
    output logic [CNT_W-1:0]     pkt_cnt
);

    arb_state_e           state;
    logic [PORT_W-1:0]    grant;
    logic [PORT_W-1:0]    last_grant;

    logic [NUM_PORTS-1:0] req;
    logic                 pick_any;
    logic [PORT_W-1:0]    pick_winner;

    logic                 out_free;
    logic                 g_valid;
    logic                 g_last;
    logic [AXIS_DW-1:0]   g_data;
    logic [AXIS_KW-1:0]   g_keep;
    logic                 accept;
    logic [NUM_PORTS-1:0] s_ready_c;

    assign req = bus.s_valid & en_mask;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .any        (pick_any),
        .winner     (pick_winner)
    );

    // Output slot can take a beat when empty or draining this cycle.
    assign out_free = !bus.m_valid || bus.m_ready;
    assign g_valid  = bus.s_valid[grant];
    assign g_last   = bus.s_last[grant];
    assign g_data   = bus.s_data[32'(grant)*AXIS_DW +: AXIS_DW];
    assign g_keep   = bus.s_keep[32'(grant)*AXIS_KW +: AXIS_KW];
    assign accept   = (state == XFER) && g_valid && out_free && !rst;

    always_comb begin
        s_ready_c = '0;
        if (state == XFER && !rst) s_ready_c[grant] = out_free;
    end

    assign bus.s_ready = s_ready_c;

    // Arbitration state, output register and packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= PORT_W'(NUM_PORTS - 1);
            busy        <= 1'b0;
            pkt_cnt     <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_keep  <= '0;
            bus.m_last  <= 1'b0;
            bus.m_src   <= '0;
        end else begin
            if (bus.m_valid && bus.m_ready && bus.m_last) pkt_cnt <= pkt_cnt + CNT_W'(1);

            if (accept) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= g_data;
                bus.m_keep  <= g_keep;
                bus.m_last  <= g_last;
                bus.m_src   <= grant;
            end else if (bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_winner;
                        state <= XFER;
                        busy  <= 1'b1;
                    end
                end
                XFER: begin
                    if (accept && g_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Randomized bench for axis_rr_pkt_arbiter against a packet-level round-robin reference model.
module tb_axis_rr_pkt_arbiter;
    import axis_tg_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned PW = 2;
    localparam int unsigned DW = AXIS_DW;
    localparam int unsigned KW = AXIS_KW;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] en_mask;
    logic          busy, busy4;
    logic [31:0]   pkt_cnt;
    logic [3:0]    pkt_cnt4;

    int errors = 0;
    int checks = 0;

    axis_rr_pkt_arbiter_if #(.NUM_PORTS(NP), .PORT_W(PW)) bus  ();
    axis_rr_pkt_arbiter_if #(.NUM_PORTS(NP), .PORT_W(PW)) bus4 ();

    assign bus4.s_valid = bus.s_valid;
    assign bus4.s_data  = bus.s_data;
    assign bus4.s_keep  = bus.s_keep;
    assign bus4.s_last  = bus.s_last;
    assign bus4.m_ready = bus.m_ready;

    axis_rr_pkt_arbiter #(.NUM_PORTS(NP), .PORT_W(PW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .en_mask(en_mask), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    axis_rr_pkt_arbiter #(.NUM_PORTS(NP), .PORT_W(PW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .en_mask(en_mask), .busy(busy4), .pkt_cnt(pkt_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Generator state per port: current beat held until accepted.
    bit          gv    [NP];
    int          gbeat [NP];
    int          glen  [NP];
    bit          glast [NP];
    logic [DW-1:0] gdata [NP];
    logic [KW-1:0] gkeep [NP];

    int cfg_ports, len_min, len_max, p_valid, p_ready, budget;
    logic [NP-1:0] cur_mask;
    bit mr;

    // Reference model: packet owner (-1 when arbitrating), last owner, output slot, counter.
    bit          model_ok = 1'b0;
    int          own, lastg;
    bit          mv, ml;
    logic [DW-1:0] md;
    logic [KW-1:0] mk;
    int          msrc;
    logic [31:0] cnt;

    int obs_q[$];

    task automatic model_reset();
        own = -1; lastg = NP - 1; mv = 0; ml = 0; md = '0; mk = '0; msrc = 0; cnt = '0;
        model_ok = 1'b1;
    endtask

    task automatic cycle(input bit do_rst);
        logic [NP-1:0] exp_rdy;
        bit acc;
        int old_own;
        @(negedge clk);
        if (model_ok) begin
            check("m_valid", DW'(bus.m_valid), DW'(mv));
            if (mv) begin
                check("m_data", bus.m_data, md);
                check("m_keep", DW'(bus.m_keep), DW'(mk));
                check("m_last", DW'(bus.m_last), DW'(ml));
                check("m_src", DW'(bus.m_src), DW'(msrc));
            end
            check("busy", DW'(busy), DW'(own >= 0));
            check("pkt_cnt", DW'(pkt_cnt), DW'(cnt));
            check("pkt_cnt4", DW'(pkt_cnt4), DW'(cnt[3:0]));
            check("m_valid4", DW'(bus4.m_valid), DW'(mv));
        end
        for (int p = 0; p < int'(NP); p++) begin
            if (!do_rst && !gv[p] && cfg_ports[p] && ($urandom_range(99) < 32'(p_valid))) begin
                if (gbeat[p] != 0 || budget != 0) begin
                    if (gbeat[p] == 0) begin
                        if (budget > 0) budget--;
                        glen[p] = int'($urandom_range(32'(len_max), 32'(len_min)));
                    end
                    gv[p] = 1'b1;
                    for (int w = 0; w < int'(DW / 32); w++) gdata[p][w*32 +: 32] = $urandom;
                    gkeep[p] = {$urandom, $urandom};
                    glast[p] = (gbeat[p] == glen[p] - 1);
                end
            end
        end
        mr = ($urandom_range(99) < 32'(p_ready));
        for (int p = 0; p < int'(NP); p++) begin
            bus.s_valid[p]            = gv[p];
            bus.s_last[p]             = glast[p];
            bus.s_data[p*DW +: DW]    = gdata[p];
            bus.s_keep[p*KW +: KW]    = gkeep[p];
        end
        bus.m_ready = mr;
        en_mask     = cur_mask;
        rst         = do_rst;
        #1;
        exp_rdy = '0;
        if (!do_rst && model_ok && own >= 0) exp_rdy[own] = !mv || mr;
        if (do_rst || model_ok) begin
            check("s_ready", DW'(bus.s_ready), DW'(exp_rdy));
            check("s_ready4", DW'(bus4.s_ready), DW'(exp_rdy));
        end
        if (bus.m_valid && bus.m_ready && bus.m_last) obs_q.push_back(int'(bus.m_src));
        if (do_rst) begin
            model_reset();
            for (int p = 0; p < int'(NP); p++) begin gv[p] = 0; gbeat[p] = 0; glast[p] = 0; end
        end else if (model_ok) begin
            old_own = own;
            acc = (old_own >= 0) && gv[old_own] && (!mv || mr);
            if (mv && mr && ml) cnt = cnt + 1;
            if (acc) begin
                mv = 1; md = gdata[old_own]; mk = gkeep[old_own]; ml = glast[old_own]; msrc = old_own;
            end else if (mr) begin
                mv = 0;
            end
            if (old_own < 0) begin
                for (int k = 1; k <= int'(NP); k++) begin
                    if (own < 0 && gv[(lastg + k) % NP] && cur_mask[(lastg + k) % NP]) own = (lastg + k) % NP;
                end
            end else if (acc && glast[old_own]) begin
                lastg = old_own;
                own = -1;
            end
            if (acc) begin
                gbeat[old_own] = glast[old_own] ? 0 : gbeat[old_own] + 1;
                gv[old_own] = 0;
            end
        end
    endtask

    task automatic set_cfg(input int ports, input int lmin, input int lmax, input int pv,
                           input int pr, input int bud);
        cfg_ports = ports; len_min = lmin; len_max = lmax; p_valid = pv; p_ready = pr; budget = bud;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        int exp_fair[6] = '{0, 1, 2, 3, 0, 1};
        int bad_ports;
        bit seen;
        rst = 1'b1; en_mask = '0; cur_mask = 4'hF; mr = 0;
        bus.s_valid = '0; bus.s_last = '0; bus.s_data = '0; bus.s_keep = '0; bus.m_ready = 1'b0;
        for (int p = 0; p < int'(NP); p++) begin gv[p] = 0; gbeat[p] = 0; glen[p] = 1; glast[p] = 0; end
        set_cfg(0, 1, 1, 0, 100, 0);

        // Reset state
        cycle(1'b1); cycle(1'b1);
        @(posedge clk); #1;
        check("rst_m_valid", DW'(bus.m_valid), '0);
        check("rst_m_data", bus.m_data, '0);
        check("rst_m_src", DW'(bus.m_src), '0);
        check("rst_pkt_cnt", DW'(pkt_cnt), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_s_ready", DW'(bus.s_ready), '0);

        // Single 3-beat packet from port 2
        obs_q.delete();
        set_cfg(4'b0100, 3, 3, 100, 100, 1);
        run(12);
        @(posedge clk); #1;
        check("single_cnt", DW'(pkt_cnt), DW'(1));
        check("single_npkt", DW'(obs_q.size()), DW'(1));
        if (obs_q.size() > 0) check("single_src", DW'(obs_q[0]), DW'(2));

        // Fairness: all ports, 2-beat packets
        cycle(1'b1);
        obs_q.delete();
        set_cfg(4'hF, 2, 2, 100, 100, 6);
        run(30);
        @(posedge clk); #1;
        check("fair_cnt", DW'(pkt_cnt), DW'(6));
        check("fair_npkt", DW'(obs_q.size()), DW'(6));
        for (int i = 0; i < 6 && i < obs_q.size(); i++)
            check($sformatf("fair_src%0d", i), DW'(obs_q[i]), DW'(exp_fair[i]));

        // Backpressure with 4-beat packets
        set_cfg(4'hF, 4, 4, 100, 50, 8);
        run(120);

        // Mask 0101, then drop port 0 mid-packet
        cycle(1'b1);
        obs_q.delete();
        cur_mask = 4'b0101;
        set_cfg(4'hF, 3, 3, 100, 100, -1);
        run(20);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b0);
            seen = (own == 0) && (gbeat[0] == 1);
        end
        check("mask_wait", DW'(seen), DW'(1));
        cur_mask = 4'b0100;
        run(30);
        bad_ports = 0;
        foreach (obs_q[i]) if (obs_q[i] == 1 || obs_q[i] == 3) bad_ports++;
        check("mask_bad_ports", DW'(bad_ports), '0);
        check("mask_last_src", DW'(obs_q[$]), DW'(2));

        // Mid-packet reset at beat 2 of a 4-beat packet
        cycle(1'b1);
        cur_mask = 4'hF;
        set_cfg(4'hF, 4, 4, 100, 100, -1);
        run(3);
        cycle(1'b1);
        @(posedge clk); #1;
        check("mrst_m_valid", DW'(bus.m_valid), '0);
        check("mrst_pkt_cnt", DW'(pkt_cnt), '0);
        check("mrst_s_ready", DW'(bus.s_ready), '0);
        obs_q.delete();
        run(10);
        if (obs_q.size() > 0) check("mrst_first_src", DW'(obs_q[0]), '0);
        else check("mrst_first_pkt", '0, DW'(1));

        // Counter wrap on the 4-bit instance
        cycle(1'b1);
        set_cfg(4'hF, 1, 1, 100, 100, 17);
        run(60);
        @(posedge clk); #1;
        check("wrap_cnt4", DW'(pkt_cnt4), DW'(1));
        check("wrap_cnt32", DW'(pkt_cnt), DW'(17));

        // Random traffic with mask churn and occasional reset
        set_cfg(4'hF, 1, 5, 70, 70, -1);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(29) == 0) cur_mask = 4'($urandom);
            cycle($urandom_range(199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
